// File: rtl/pulse_pkg.sv
// pulse_pkg: shared definitions for the RFSoC sample path (pulse_gen / pulse_detect).
// Host FIFO word layout, command codes and the default sample-beat geometry.
package pulse_pkg;

  localparam int unsigned NSAMP_DEF   = 16;
  localparam int unsigned SAMP_W_DEF  = 16;
  localparam int unsigned BEAT_W_DEF  = NSAMP_DEF * SAMP_W_DEF;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned CMD_W       = 8;
  localparam int unsigned CRS_W       = 16;
  localparam int unsigned FINE_W      = 8;
  localparam int unsigned CMD_LSB     = 24;
  localparam int unsigned CRS_LSB     = 8;
  localparam int unsigned FINE_LSB    = 0;

  localparam logic [CMD_W-1:0] CMD_SYNC  = 8'h00;
  localparam logic [CMD_W-1:0] CMD_EVENT = 8'h01;
  localparam logic [CMD_W-1:0] CMD_WRAP  = 8'h02;

  // Host FIFO word: [31:24] cmd, [23:8] coarse, [7:0] fine
  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [CRS_W-1:0]  coarse;
    logic [FINE_W-1:0] fine;
  } evt_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DEAD  = 2'd2
  } det_state_t;

  function automatic evt_word_t make_word(input logic [CMD_W-1:0]  cmd,
                                          input logic [CRS_W-1:0]  coarse,
                                          input logic [FINE_W-1:0] fine);
    evt_word_t w;
    w.cmd    = cmd;
    w.coarse = coarse;
    w.fine   = fine;
    return w;
  endfunction

endpackage

// File: rtl/pulse_detect_if.sv
// pulse_detect_if: ADC AXIS sample stream plus host event-FIFO write port.
// slave = detector side, master = source/sink side.
interface pulse_detect_if;
  import pulse_pkg::*;

  logic [BEAT_W_DEF-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic                  fifo_full;
  logic [WORD_W-1:0]     fifo_data;
  logic                  fifo_write;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, fifo_full,
    output s_axis_tready, fifo_data, fifo_write
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, fifo_full,
    input  s_axis_tready, fifo_data, fifo_write
  );

endinterface

// File: rtl/pulse_detect_prienc.sv
// pulse_detect_prienc: lowest-index priority encoder with found flag (purely combinational).
module pulse_detect_prienc #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             found_c,
  output logic [IDX_W-1:0] idx_c
);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found_c = 1'b1;
        idx_c   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pulse_detect.sv
// pulse_detect: rising threshold-crossing detector on the ADC beat stream, writing timestamped
// words to the host FIFO. Define PULSE_DETECT_WRAP_MARK_EN to emit coarse-wrap marker words.
module pulse_detect
  import pulse_pkg::*;
#(
  parameter int unsigned NSAMP      = NSAMP_DEF,
  parameter int unsigned SAMP_W     = SAMP_W_DEF,
  parameter int unsigned COARSE_W   = 16,
  parameter int unsigned DEAD_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  pulse_detect_if.slave     bus,
  input  logic              enable,
  input  logic              sync,
  input  logic [SAMP_W-1:0] threshold,
  output logic [15:0]       drop_count,
  output logic              busy
);

  localparam int unsigned IDX_W  = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam int unsigned DEAD_W = (DEAD_BEATS > 1) ? $clog2(DEAD_BEATS) : 1;
  localparam int unsigned QCNT_W = 2;
  localparam int unsigned DROP_W = 16;

  // ---------------- stage 0: compare vector and coarse stamp ----------------
  logic signed [SAMP_W-1:0] samp [NSAMP];
  logic signed [SAMP_W-1:0] prev_sample;
  logic [NSAMP-1:0]         ge_c;
  logic [NSAMP-1:0]         cross_c;
  logic                     prev_ge_c;

  for (genvar g = 0; g < NSAMP; g++) begin : g_cmp
    assign samp[g] = bus.s_axis_tdata[(NSAMP-1-g)*SAMP_W +: SAMP_W];
    assign ge_c[g] = samp[g] >= $signed(threshold);
  end

  // Sample 0's predecessor is the last sample of the previous valid beat
  assign prev_ge_c = prev_sample >= $signed(threshold);
  assign cross_c   = ge_c & ~{ge_c[NSAMP-2:0], prev_ge_c};

  logic [COARSE_W-1:0] coarse;
  logic [COARSE_W-1:0] coarse_nxt;
  logic [COARSE_W-1:0] stamp_c;
`ifdef PULSE_DETECT_WRAP_MARK_EN
  logic                wrap_c;
`endif

  always_comb begin
    coarse_nxt = coarse;
    stamp_c    = coarse;
`ifdef PULSE_DETECT_WRAP_MARK_EN
    wrap_c     = 1'b0;
`endif
    if (sync) begin
      stamp_c    = '0;
      coarse_nxt = bus.s_axis_tvalid ? COARSE_W'(1) : '0;
    end else if (bus.s_axis_tvalid) begin
      coarse_nxt = coarse + COARSE_W'(1);
`ifdef PULSE_DETECT_WRAP_MARK_EN
      wrap_c     = &coarse;
`endif
    end
  end

  // ---------------- stage 1 registers ----------------
  logic                s1_valid;
  logic                s1_sync;
  logic [NSAMP-1:0]    s1_cross;
  logic [COARSE_W-1:0] s1_coarse;
`ifdef PULSE_DETECT_WRAP_MARK_EN
  logic                s1_wrap;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coarse      <= '0;
      prev_sample <= '0;
      s1_valid    <= 1'b0;
      s1_sync     <= 1'b0;
      s1_cross    <= '0;
      s1_coarse   <= '0;
`ifdef PULSE_DETECT_WRAP_MARK_EN
      s1_wrap     <= 1'b0;
`endif
    end else begin
      coarse    <= coarse_nxt;
      s1_valid  <= bus.s_axis_tvalid;
      s1_sync   <= sync;
      s1_cross  <= bus.s_axis_tvalid ? cross_c : '0;
      s1_coarse <= stamp_c;
`ifdef PULSE_DETECT_WRAP_MARK_EN
      s1_wrap   <= wrap_c;
`endif
      if (bus.s_axis_tvalid) begin
        prev_sample <= samp[NSAMP-1];
      end
    end
  end

  // ---------------- stage 2: encode, FSM, enqueue ----------------
  logic             found_c;
  logic [IDX_W-1:0] idx_c;

  pulse_detect_prienc #(
    .N     (NSAMP),
    .IDX_W (IDX_W)
  ) u_prienc (
    .req     (s1_cross),
    .found_c (found_c),
    .idx_c   (idx_c)
  );

  det_state_t        state_q;
  det_state_t        state_nxt;
  logic [DEAD_W-1:0] dead_q;
  logic [DEAD_W-1:0] dead_nxt;
  logic              evt_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dead_q  <= '0;
    end else begin
      state_q <= state_nxt;
      dead_q  <= dead_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    dead_nxt  = dead_q;
    evt_c     = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
      dead_nxt  = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_nxt = ST_ARMED;
        ST_ARMED: begin
          if (s1_valid && found_c) begin
            evt_c = 1'b1;
            if (DEAD_BEATS > 0) begin
              state_nxt = ST_DEAD;
              dead_nxt  = '0;
            end
          end
        end
        ST_DEAD: begin
          // Crossings inside the dead window are ignored; only valid beats count
          if (s1_valid) begin
            if (dead_q == DEAD_W'(DEAD_BEATS - 1)) begin
              state_nxt = ST_ARMED;
              dead_nxt  = '0;
            end else begin
              dead_nxt = dead_q + DEAD_W'(1);
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          dead_nxt  = '0;
        end
      endcase
    end
  end

  // Marker (sync or wrap) always precedes an event from the same beat
  logic            mark_v_c;
  logic [CMD_W-1:0] mark_cmd_c;
  evt_word_t       push_w_c [2];
  logic [1:0]      push_v_c;

  always_comb begin
`ifdef PULSE_DETECT_WRAP_MARK_EN
    mark_v_c   = s1_sync | s1_wrap;
    mark_cmd_c = s1_sync ? CMD_SYNC : CMD_WRAP;
`else
    mark_v_c   = s1_sync;
    mark_cmd_c = CMD_SYNC;
`endif
    push_w_c[0] = make_word(mark_cmd_c, '0, '0);
    push_v_c[0] = mark_v_c;
    push_w_c[1] = make_word(CMD_EVENT, CRS_W'(s1_coarse), FINE_W'(idx_c));
    push_v_c[1] = evt_c;
  end

  // ---------------- 2-entry staging queue (head in q0) ----------------
  evt_word_t         q0, q1, q0_nxt, q1_nxt;
  logic [QCNT_W-1:0] q_cnt, q_cnt_nxt;
  logic              pop_c;
  logic [1:0]        drop_inc_c;
  logic [DROP_W:0]   drop_sum_c;

  always_comb begin
    pop_c      = (q_cnt != '0) && !bus.fifo_full;
    q0_nxt     = q0;
    q1_nxt     = q1;
    q_cnt_nxt  = q_cnt;
    drop_inc_c = '0;
    if (pop_c) begin
      q0_nxt    = q1;
      q_cnt_nxt = q_cnt - QCNT_W'(1);
    end
    for (int k = 0; k < 2; k++) begin
      if (push_v_c[k]) begin
        if (q_cnt_nxt == QCNT_W'(0)) begin
          q0_nxt    = push_w_c[k];
          q_cnt_nxt = QCNT_W'(1);
        end else if (q_cnt_nxt == QCNT_W'(1)) begin
          q1_nxt    = push_w_c[k];
          q_cnt_nxt = QCNT_W'(2);
        end else begin
          drop_inc_c = drop_inc_c + 2'd1;
        end
      end
    end
  end

  assign drop_sum_c = {1'b0, drop_count} + (DROP_W+1)'(drop_inc_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q0                <= '0;
      q1                <= '0;
      q_cnt             <= '0;
      bus.s_axis_tready <= 1'b1;
      bus.fifo_write    <= 1'b0;
      bus.fifo_data     <= '0;
      drop_count        <= '0;
      busy              <= 1'b0;
    end else begin
      q0                <= q0_nxt;
      q1                <= q1_nxt;
      q_cnt             <= q_cnt_nxt;
      bus.s_axis_tready <= 1'b1;
      bus.fifo_write    <= pop_c;
      if (pop_c) begin
        bus.fifo_data <= q0;
      end
      drop_count <= drop_sum_c[DROP_W] ? {DROP_W{1'b1}} : drop_sum_c[DROP_W-1:0];
      busy       <= (state_nxt == ST_DEAD) || (q_cnt_nxt != '0);
    end
  end

endmodule

// File: tb/tb_pulse_detect.sv
// tb_pulse_detect: scoreboard bench for pulse_detect; a beat-level model pushes expected FIFO
// words as stimulus is driven and a monitor pops/compares on every fifo_write.
`timescale 1ns/1ps
module tb_pulse_detect;
  import pulse_pkg::*;

  localparam int unsigned CW = 4;
  localparam int unsigned DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        sync = 1'b0;
  logic [15:0] threshold = 16'h1000;
  logic [15:0] drop_count;
  logic        busy;

  always #5 clk = ~clk;

  pulse_detect_if bus();

  pulse_detect #(
    .NSAMP      (16),
    .SAMP_W     (16),
    .COARSE_W   (CW),
    .DEAD_BEATS (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .enable     (enable),
    .sync       (sync),
    .threshold  (threshold),
    .drop_count (drop_count),
    .busy       (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_wr   = 0;
  int n_wrap = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- beat-level reference model ----------------
  logic [31:0]        exp_q[$];
  int                 m_coarse = 0;
  logic signed [15:0] m_prev = 16'sd0;
  int                 m_dead = 0;
  bit                 m_en = 1'b0;
  bit                 m_full = 1'b0;
  int                 m_held = 0;
  int                 m_drop = 0;

  task automatic push_word(input logic [31:0] w);
    if (m_full) begin
      if (m_held < 2) begin
        exp_q.push_back(w);
        m_held++;
      end else begin
        m_drop++;
      end
    end else begin
      exp_q.push_back(w);
    end
  endtask

  function automatic logic [255:0] beat_const(input logic [15:0] v);
    logic [255:0] b;
    for (int i = 0; i < 16; i++) b[255-16*i -: 16] = v;
    return b;
  endfunction

  function automatic logic [255:0] beat_put(input logic [255:0] b, input int i, input logic [15:0] v);
    logic [255:0] r;
    r = b;
    r[255-16*i -: 16] = v;
    return r;
  endfunction

  task automatic send_beat(input logic [255:0] d, input bit s);
    logic signed [15:0] cur;
    logic signed [15:0] prv;
    int stamp;
    int fine;
    bus.s_axis_tdata  = d;
    bus.s_axis_tvalid = 1'b1;
    sync              = s;
    if (s) begin
      push_word(32'h0000_0000);
      stamp    = 0;
      m_coarse = 1;
    end else begin
`ifdef PULSE_DETECT_WRAP_MARK_EN
      if (m_coarse == (1 << CW) - 1) push_word(32'h0200_0000);
`endif
      stamp    = m_coarse;
      m_coarse = (m_coarse + 1) % (1 << CW);
    end
    fine = -1;
    for (int i = 0; i < 16; i++) begin
      cur = d[255-16*i -: 16];
      prv = (i == 0) ? m_prev : d[255-16*(i-1) -: 16];
      if (fine < 0 && cur >= $signed(threshold) && prv < $signed(threshold)) fine = i;
    end
    if (m_en) begin
      if (m_dead > 0) m_dead--;
      else if (fine >= 0) begin
        push_word({8'h01, 16'(stamp), 8'(fine)});
        m_dead = DB;
      end
    end
    m_prev = d[15:0];
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    sync              = 1'b0;
  endtask

  task automatic send_sync();
    sync = 1'b1;
    push_word(32'h0000_0000);
    m_coarse = 0;
    @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    idle(3);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst && bus.fifo_write) begin
      logic [31:0] e;
      n_wr++;
      if (bus.fifo_data[31:24] == 8'h02) n_wrap++;
      chk("write_expected", {31'd0, bus.fifo_write}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("fifo_word", bus.fifo_data, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int wr0;
    int wrap0;
    logic [255:0] b;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.fifo_full     = 1'b0;
    idle(3);
    chk("rst_tready", {31'd0, bus.s_axis_tready}, 32'd1);
    chk("rst_fifo_write", {31'd0, bus.fifo_write}, 32'd0);
    chk("rst_fifo_data", bus.fifo_data, 32'd0);
    chk("rst_drop_count", {16'd0, drop_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    idle(2);
    enable = 1'b1;
    m_en   = 1'b1;
    idle(2);

    // basic event: sync marker then 0x01000507, written two cycles after the beat
    send_sync();
    repeat (5) send_beat('0, 1'b0);
    send_beat(beat_put('0, 7, 16'h7FFF), 1'b0);
    @(negedge clk);
    chk("lat_early", {31'd0, bus.fifo_write}, 32'd0);
    @(negedge clk);
    chk("lat_on_time", {31'd0, bus.fifo_write}, 32'd1);
    chk("basic_word", bus.fifo_data, 32'h0100_0507);
    repeat (4) send_beat('0, 1'b0);
    drain("drain_basic");

    // cross-beat edge: high tail then high head -> nothing; low tail then high head -> fine 0
    send_beat(beat_const(16'h2000), 1'b0);
    repeat (4) send_beat(beat_const(16'h2000), 1'b0);
    send_beat(beat_const(16'h2000), 1'b0);
    send_beat(beat_put(beat_const(16'h2000), 0, 16'h3000), 1'b0);
    send_beat('0, 1'b0);
    send_beat(beat_put('0, 0, 16'h3000), 1'b0);
    repeat (4) send_beat('0, 1'b0);
    drain("drain_crossbeat");

    // dead time: crossings on beats 10, 12, 15 after sync
    send_sync();
    for (int k = 0; k < 16; k++) begin
      b = (k == 10 || k == 12 || k == 15) ? beat_put('0, 3, 16'h7FFF) : '0;
      send_beat(b, 1'b0);
    end
    repeat (4) send_beat('0, 1'b0);
    drain("drain_dead");

    // backpressure: 4 words into a 2-entry queue behind a full FIFO
    bus.fifo_full = 1'b1;
    m_full = 1'b1;
    m_held = 0;
    wr0 = n_wr;
    send_sync();
    for (int k = 0; k < 3; k++) begin
      send_beat(beat_put('0, 2, 16'h7FFF), 1'b0);
      repeat (4) send_beat('0, 1'b0);
    end
    idle(4);
    chk("bp_no_write", 32'(n_wr - wr0), 32'd0);
    chk("bp_fifo_write", {31'd0, bus.fifo_write}, 32'd0);
    chk("bp_drop_count", {16'd0, drop_count}, 32'(m_drop));
    chk("bp_drop_two", {16'd0, drop_count}, 32'd2);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    bus.fifo_full = 1'b0;
    m_full = 1'b0;
    wr0 = n_wr;
    idle(6);
    chk("bp_drained", 32'(n_wr - wr0), 32'd2);
    drain("drain_bp");

    // coarse wrap: 16 beats after sync
    wrap0 = n_wrap;
    send_sync();
    repeat (17) send_beat('0, 1'b0);
    drain("drain_wrap");
`ifdef PULSE_DETECT_WRAP_MARK_EN
    chk("wrap_marker", 32'(n_wrap - wrap0), 32'd1);
`else
    chk("wrap_marker", 32'(n_wrap - wrap0), 32'd0);
`endif

    // negative threshold, ramp -5000 .. -4000
    threshold = 16'hF000;
    b = '0;
    for (int i = 0; i < 16; i++) b = beat_put(b, i, 16'(-5000 + (1000 * i) / 15));
    send_beat(b, 1'b0);
    idle(4);
    chk("neg_busy_dead", {31'd0, busy}, 32'd1);
    drain("drain_neg");

    // asynchronous reset while in DEAD
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_tready", {31'd0, bus.s_axis_tready}, 32'd1);
    chk("mid_rst_fifo_write", {31'd0, bus.fifo_write}, 32'd0);
    chk("mid_rst_fifo_data", bus.fifo_data, 32'd0);
    chk("mid_rst_drop_count", {16'd0, drop_count}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    m_coarse = 0;
    m_prev   = 16'sd0;
    m_dead   = 0;
    m_drop   = 0;
    idle(2);
    rst = 1'b1;
    idle(2);

    // recovery after reset
    send_sync();
    send_beat(beat_const(16'hEC78), 1'b0);
    send_beat(beat_put(beat_const(16'hEC78), 5, 16'h0000), 1'b0);
    repeat (4) send_beat(beat_const(16'hEC78), 1'b0);
    drain("drain_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
